// File: rtl/pipeline_control.sv
// ============================================================================
// Module   : pipeline_control
// Purpose  : Carries ID control bundles through ID/EX, EX/MEM and MEM/WB,
//            stalls the front end on load-use and bubbles ID/EX on flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_control #(
  parameter int unsigned REG_ADDR_WIDTH    = 5,
  parameter int unsigned STALL_COUNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   idWriteBackControl,
  input  logic [2:0]                   idMemAccessControl,
  input  logic [3:0]                   idCalculationControl,
  input  logic [REG_ADDR_WIDTH-1:0]    idRs,
  input  logic [REG_ADDR_WIDTH-1:0]    idRt,
  input  logic [REG_ADDR_WIDTH-1:0]    idRd,
  input  logic                         branchTaken,
  output logic [1:0]                   exWriteBackControl,
  output logic [2:0]                   exMemAccessControl,
  output logic [3:0]                   exCalculationControl,
  output logic [REG_ADDR_WIDTH-1:0]    exDest,
  output logic [REG_ADDR_WIDTH-1:0]    exRt,
  output logic [1:0]                   memWriteBackControl,
  output logic [2:0]                   memMemAccessControl,
  output logic [REG_ADDR_WIDTH-1:0]    memDest,
  output logic [1:0]                   wbWriteBackControl,
  output logic [REG_ADDR_WIDTH-1:0]    wbDest,
  output logic                         pcWrite,
  output logic                         ifIdWrite,
  output logic                         ifIdFlush,
  output logic [STALL_COUNT_WIDTH-1:0] stallCount
);

  localparam logic [STALL_COUNT_WIDTH-1:0] c_one = {{(STALL_COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                   r_ex_wb;
  logic [2:0]                   r_ex_mem;
  logic [3:0]                   r_ex_calc;
  logic [REG_ADDR_WIDTH-1:0]    r_ex_rt;
  logic [REG_ADDR_WIDTH-1:0]    r_ex_rd;
  logic [1:0]                   r_mem_wb;
  logic [2:0]                   r_mem_mem;
  logic [REG_ADDR_WIDTH-1:0]    r_mem_dest;
  logic [1:0]                   r_wb_wb;
  logic [REG_ADDR_WIDTH-1:0]    r_wb_dest;
  logic [STALL_COUNT_WIDTH-1:0] r_stall_cnt;

  logic                         w_load_use;
  logic                         w_stall;
  logic                         w_bubble;
  logic [REG_ADDR_WIDTH-1:0]    w_ex_dest;

  assign w_ex_dest  = r_ex_calc[3] ? r_ex_rd : r_ex_rt;
  assign w_load_use = r_ex_mem[1] && (r_ex_rt != '0) &&
                      ((r_ex_rt == idRs) || (r_ex_rt == idRt));
  // A taken branch discards the ID instruction, so its hazard is irrelevant.
  assign w_stall    = w_load_use && !branchTaken;
  assign w_bubble   = w_load_use || branchTaken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_wb     <= '0;
      r_ex_mem    <= '0;
      r_ex_calc   <= '0;
      r_ex_rt     <= '0;
      r_ex_rd     <= '0;
      r_mem_wb    <= '0;
      r_mem_mem   <= '0;
      r_mem_dest  <= '0;
      r_wb_wb     <= '0;
      r_wb_dest   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_bubble) begin
        r_ex_wb   <= '0;
        r_ex_mem  <= '0;
        r_ex_calc <= '0;
        r_ex_rt   <= '0;
        r_ex_rd   <= '0;
      end else begin
        r_ex_wb   <= idWriteBackControl;
        r_ex_mem  <= idMemAccessControl;
        r_ex_calc <= idCalculationControl;
        r_ex_rt   <= idRt;
        r_ex_rd   <= idRd;
      end
      r_mem_wb   <= r_ex_wb;
      r_mem_mem  <= r_ex_mem;
      r_mem_dest <= w_ex_dest;
      r_wb_wb    <= r_mem_wb;
      r_wb_dest  <= r_mem_dest;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_one;
      end
    end
  end

  assign exWriteBackControl   = r_ex_wb;
  assign exMemAccessControl   = r_ex_mem;
  assign exCalculationControl = r_ex_calc;
  assign exDest               = w_ex_dest;
  assign exRt                 = r_ex_rt;
  assign memWriteBackControl  = r_mem_wb;
  assign memMemAccessControl  = r_mem_mem;
  assign memDest              = r_mem_dest;
  assign wbWriteBackControl   = r_wb_wb;
  assign wbDest               = r_wb_dest;
  assign pcWrite              = !w_stall;
  assign ifIdWrite            = !w_stall;
  assign ifIdFlush            = branchTaken;
  assign stallCount           = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_control.sv
// ============================================================================
// Module   : tb_pipeline_control
// Purpose  : Directed vector bench for pipeline_control (default and 2-bit
//            stall counter instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] id_wb = '0;
  logic [2:0] id_mem = '0;
  logic [3:0] id_calc = '0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       br = 1'b0;

  logic [1:0]  ex_wb, mem_wb, wb_wb, s_ex_wb, s_mem_wb, s_wb_wb;
  logic [2:0]  ex_mem, mem_mem, s_ex_mem, s_mem_mem;
  logic [3:0]  ex_calc, s_ex_calc;
  logic [4:0]  ex_dest, ex_rt, mem_dest, wb_dest;
  logic [4:0]  s_ex_dest, s_ex_rt, s_mem_dest, s_wb_dest;
  logic        pc_write, ifid_write, ifid_flush, s_pc, s_ifid_w, s_flush;
  logic [15:0] stall_cnt;
  logic [1:0]  s_stall_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipeline_control #(.REG_ADDR_WIDTH(5), .STALL_COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .idWriteBackControl(id_wb), .idMemAccessControl(id_mem), .idCalculationControl(id_calc),
    .idRs(id_rs), .idRt(id_rt), .idRd(id_rd), .branchTaken(br),
    .exWriteBackControl(ex_wb), .exMemAccessControl(ex_mem), .exCalculationControl(ex_calc),
    .exDest(ex_dest), .exRt(ex_rt),
    .memWriteBackControl(mem_wb), .memMemAccessControl(mem_mem), .memDest(mem_dest),
    .wbWriteBackControl(wb_wb), .wbDest(wb_dest),
    .pcWrite(pc_write), .ifIdWrite(ifid_write), .ifIdFlush(ifid_flush), .stallCount(stall_cnt)
  );

  pipeline_control #(.REG_ADDR_WIDTH(5), .STALL_COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst),
    .idWriteBackControl(id_wb), .idMemAccessControl(id_mem), .idCalculationControl(id_calc),
    .idRs(id_rs), .idRt(id_rt), .idRd(id_rd), .branchTaken(br),
    .exWriteBackControl(s_ex_wb), .exMemAccessControl(s_ex_mem), .exCalculationControl(s_ex_calc),
    .exDest(s_ex_dest), .exRt(s_ex_rt),
    .memWriteBackControl(s_mem_wb), .memMemAccessControl(s_mem_mem), .memDest(s_mem_dest),
    .wbWriteBackControl(s_wb_wb), .wbDest(s_wb_dest),
    .pcWrite(s_pc), .ifIdWrite(s_ifid_w), .ifIdFlush(s_flush), .stallCount(s_stall_cnt)
  );

  typedef struct {
    logic [1:0]  i_wb;
    logic [2:0]  i_mem;
    logic [3:0]  i_calc;
    logic [4:0]  i_rs, i_rt, i_rd;
    logic        i_br;
    logic        pc, fl;
    logic [1:0]  e_wb;
    logic [2:0]  e_mem;
    logic [3:0]  e_calc;
    logic [4:0]  e_dest, e_rt;
    logic [1:0]  m_wb;
    logic [2:0]  m_mem;
    logic [4:0]  m_dest;
    logic [1:0]  w_wb;
    logic [4:0]  w_dest;
    logic [15:0] stall;
  } vec_t;

  vec_t vec [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] mem, input logic [3:0] calc,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic b);
    id_wb = wb; id_mem = mem; id_calc = calc;
    id_rs = rs; id_rt = rt; id_rd = rd; br = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_wb"},   32'(ex_wb),    0);
    check({tag, "_ex_mem"},  32'(ex_mem),   0);
    check({tag, "_ex_calc"}, 32'(ex_calc),  0);
    check({tag, "_ex_dest"}, 32'(ex_dest),  0);
    check({tag, "_ex_rt"},   32'(ex_rt),    0);
    check({tag, "_mem_wb"},  32'(mem_wb),   0);
    check({tag, "_mem_mem"}, 32'(mem_mem),  0);
    check({tag, "_mem_dest"},32'(mem_dest), 0);
    check({tag, "_wb_wb"},   32'(wb_wb),    0);
    check({tag, "_wb_dest"}, 32'(wb_dest),  0);
    check({tag, "_stall"},   32'(stall_cnt), 0);
    check({tag, "_sstall"},  32'(s_stall_cnt), 0);
  endtask

  initial begin
    // inputs: wb mem calc rs rt rd br | pc fl | ex wb mem calc dest rt | mem wb mem dest | wb wb dest | stall
    vec[0]  = '{2'b10,3'b000,4'b1100,5'd1, 5'd3, 5'd5, 1'b0, 1'b1,1'b0, 2'b10,3'b000,4'b1100,5'd5, 5'd3,  2'b00,3'b000,5'd0,  2'b00,5'd0,  16'd0};
    vec[1]  = '{2'b11,3'b010,4'b0001,5'd2, 5'd8, 5'd0, 1'b0, 1'b1,1'b0, 2'b11,3'b010,4'b0001,5'd8, 5'd8,  2'b10,3'b000,5'd5,  2'b00,5'd0,  16'd0};
    vec[2]  = '{2'b10,3'b000,4'b1100,5'd8, 5'd4, 5'd6, 1'b0, 1'b0,1'b0, 2'b00,3'b000,4'b0000,5'd0, 5'd0,  2'b11,3'b010,5'd8,  2'b10,5'd5,  16'd1};
    vec[3]  = '{2'b10,3'b000,4'b1100,5'd8, 5'd4, 5'd6, 1'b0, 1'b1,1'b0, 2'b10,3'b000,4'b1100,5'd6, 5'd4,  2'b00,3'b000,5'd0,  2'b11,5'd8,  16'd1};
    vec[4]  = '{2'b11,3'b010,4'b0001,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,1'b0, 2'b11,3'b010,4'b0001,5'd0, 5'd0,  2'b10,3'b000,5'd6,  2'b00,5'd0,  16'd1};
    vec[5]  = '{2'b10,3'b000,4'b1100,5'd0, 5'd0, 5'd7, 1'b0, 1'b1,1'b0, 2'b10,3'b000,4'b1100,5'd7, 5'd0,  2'b11,3'b010,5'd0,  2'b10,5'd6,  16'd1};
    vec[6]  = '{2'b11,3'b010,4'b0001,5'd1, 5'd8, 5'd0, 1'b0, 1'b1,1'b0, 2'b11,3'b010,4'b0001,5'd8, 5'd8,  2'b10,3'b000,5'd7,  2'b11,5'd0,  16'd1};
    vec[7]  = '{2'b10,3'b000,4'b1100,5'd9, 5'd10,5'd11,1'b0, 1'b1,1'b0, 2'b10,3'b000,4'b1100,5'd11,5'd10, 2'b11,3'b010,5'd8,  2'b10,5'd7,  16'd1};
    vec[8]  = '{2'b00,3'b110,4'b0010,5'd1, 5'd12,5'd0, 1'b0, 1'b1,1'b0, 2'b00,3'b110,4'b0010,5'd12,5'd12, 2'b10,3'b000,5'd11, 2'b11,5'd8,  16'd1};
    vec[9]  = '{2'b10,3'b000,4'b1100,5'd12,5'd0, 5'd13,1'b1, 1'b1,1'b1, 2'b00,3'b000,4'b0000,5'd0, 5'd0,  2'b00,3'b110,5'd12, 2'b10,5'd11, 16'd1};
    vec[10] = '{2'b00,3'b000,4'b0000,5'd0, 5'd0, 5'd0, 1'b0, 1'b1,1'b0, 2'b00,3'b000,4'b0000,5'd0, 5'd0,  2'b00,3'b000,5'd0,  2'b00,5'd12, 16'd1};

    // Reset state
    #2;
    check_all_zero("reset");
    check("reset_pc", 32'(pc_write), 1);
    check("reset_ifid_w", 32'(ifid_write), 1);
    check("reset_flush", 32'(ifid_flush), 0);
    tick();
    rst = 1'b0;

    // Table-driven pipeline stream
    for (int i = 0; i < 11; i++) begin
      drive(vec[i].i_wb, vec[i].i_mem, vec[i].i_calc, vec[i].i_rs, vec[i].i_rt, vec[i].i_rd, vec[i].i_br);
      #1;
      check($sformatf("v%0d_pc", i),     32'(pc_write),   32'(vec[i].pc));
      check($sformatf("v%0d_ifid_w", i), 32'(ifid_write), 32'(vec[i].pc));
      check($sformatf("v%0d_flush", i),  32'(ifid_flush), 32'(vec[i].fl));
      tick();
      check($sformatf("v%0d_ex_wb", i),    32'(ex_wb),    32'(vec[i].e_wb));
      check($sformatf("v%0d_ex_mem", i),   32'(ex_mem),   32'(vec[i].e_mem));
      check($sformatf("v%0d_ex_calc", i),  32'(ex_calc),  32'(vec[i].e_calc));
      check($sformatf("v%0d_ex_dest", i),  32'(ex_dest),  32'(vec[i].e_dest));
      check($sformatf("v%0d_ex_rt", i),    32'(ex_rt),    32'(vec[i].e_rt));
      check($sformatf("v%0d_mem_wb", i),   32'(mem_wb),   32'(vec[i].m_wb));
      check($sformatf("v%0d_mem_mem", i),  32'(mem_mem),  32'(vec[i].m_mem));
      check($sformatf("v%0d_mem_dest", i), 32'(mem_dest), 32'(vec[i].m_dest));
      check($sformatf("v%0d_wb_wb", i),    32'(wb_wb),    32'(vec[i].w_wb));
      check($sformatf("v%0d_wb_dest", i),  32'(wb_dest),  32'(vec[i].w_dest));
      check($sformatf("v%0d_stall", i),    32'(stall_cnt), 32'(vec[i].stall));
    end

    // Asynchronous reset mid-stream, with branchTaken high during reset
    drive(2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd3, 1'b0); tick();
    drive(2'b10, 3'b000, 4'b1100, 5'd4, 5'd5, 5'd6, 1'b0); tick();
    drive(2'b11, 3'b001, 4'b0001, 5'd7, 5'd9, 5'd0, 1'b0); tick();
    check("pre_rst_ex_wb", 32'(ex_wb), 32'(2'b11));
    #2;
    rst = 1'b1;
    br  = 1'b1;
    #1;
    check_all_zero("midrst");
    check("midrst_pc", 32'(pc_write), 1);
    check("midrst_ifid_w", 32'(ifid_write), 1);
    check("midrst_flush", 32'(ifid_flush), 1);
    br = 1'b0;
    #1;
    check("midrst_flush_low", 32'(ifid_flush), 0);
    tick();
    check_all_zero("rst_held");
    rst = 1'b0;
    #1;
    check("rst_rel_ex_wb", 32'(ex_wb), 0);
    tick();
    check("rst_rel_ex_mem", 32'(ex_mem), 32'(3'b001));
    check("rst_rel_ex_dest", 32'(ex_dest), 32'd9);

    // Five load-use stalls: 2-bit counter saturates, 16-bit keeps counting
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_sat;
      exp_sat = (i < 3) ? 2'(i + 1) : 2'd3;
      drive(2'b11, 3'b010, 4'b0001, 5'd1, 5'd8, 5'd0, 1'b0); tick();
      drive(2'b10, 3'b000, 4'b1100, 5'd8, 5'd2, 5'd3, 1'b0);
      #1;
      check($sformatf("sat%0d_pc", i), 32'(s_pc), 0);
      tick();
      check($sformatf("sat%0d_scount", i), 32'(s_stall_cnt), 32'(exp_sat));
      check($sformatf("sat%0d_count", i), 32'(stall_cnt), 32'(i + 1));
      #1;
      check($sformatf("sat%0d_resume_pc", i), 32'(pc_write), 1);
      tick();
      check($sformatf("sat%0d_dep_dest", i), 32'(ex_dest), 32'd3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_control.md
# pipeline_control

Pipeline control sequencer for the 5-stage datapath. Takes the decoded control bundles (writeBackControl, memAccessControl, calculationControl) produced in ID each cycle, carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers, and computes each stage's destination register. It detects load-use hazards and stalls the front end. It also applies branch flushes by inserting all-zero bubbles.

## Interface
- REG_ADDR_WIDTH, 5, register-address width
- STALL_COUNT_WIDTH, 16, width of the saturating stall counter

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- idWriteBackControl  in  2  [1]=regWrite, [0]=memToReg
- idMemAccessControl  in  3  [2]=branch, [1]=memRead, [0]=memWrite
- idCalculationControl  in  4  [3]=regDst, [2:1]=aluOp, [0]=aluSrc
- idRs, idRt, idRd  in  REG_ADDR_WIDTH each  register fields of the instruction in ID
- branchTaken  in  1  branch in EX resolved taken (driven by the EX stage)
- exWriteBackControl / exMemAccessControl / exCalculationControl  out  2/3/4  ID/EX control
- exDest  out  REG_ADDR_WIDTH  exCalculationControl[3] ? registered rd : registered rt (combinational)
- exRt  out  REG_ADDR_WIDTH  registered rt in EX
- memWriteBackControl / memMemAccessControl  out  2/3  EX/MEM control
- memDest  out  REG_ADDR_WIDTH
- wbWriteBackControl  out  2  MEM/WB control
- wbDest  out  REG_ADDR_WIDTH
- pcWrite  out  1  PC may advance
- ifIdWrite  out  1  IF/ID register may load
- ifIdFlush  out  1  clear IF/ID at the next edge
- stallCount  out  STALL_COUNT_WIDTH  load-use stall cycles since reset, saturating

## Operation
- Bubble means all control fields are 0 and the registered rs/rt/rd are 0. A bubble never writes a register or memory.
- **loadUse** (combinational) = exMemAccessControl[1] & (exRt != 0) & ((exRt == idRs) | (exRt == idRt)).
- **Flush priority.** If branchTaken=1:
  - ifIdFlush=1, pcWrite=1, ifIdWrite=1.
  - ID/EX loads a bubble.
  - The EX-stage branch advances to MEM normally.
  - loadUse is ignored this cycle and stallCount does not increment.
- **Stall.** Else if loadUse=1:
  - pcWrite=0, ifIdWrite=0, ifIdFlush=0.
  - ID/EX loads a bubble.
  - EX/MEM and MEM/WB advance normally.
  - stallCount increments by 1 and holds at all-ones.
- **Normal.** Otherwise:
  - pcWrite=1, ifIdWrite=1, ifIdFlush=0.
  - ID/EX loads the id* inputs.
- **Back end.** EX/MEM and MEM/WB always advance; the back end never stalls.
  - EX/MEM loads {exWriteBackControl, exMemAccessControl, exDest}.
  - MEM/WB loads {memWriteBackControl, memDest}.
- **Stall length.** A load-use stall lasts exactly one cycle. After the bubble the load is in MEM, so loadUse deasserts and the stalled instruction proceeds.
- **Register 0.** A register-0 destination (exRt=0) never triggers a stall.

## Timing
- All pipeline registers and stallCount update on rising clk.
- pcWrite, ifIdWrite, ifIdFlush, loadUse and exDest are combinational from the current registers, id* inputs and branchTaken. They are valid within the same cycle.
- **Latency.** An instruction's control appears:
  - on ex* 1 cycle after being presented on id*,
  - on mem* after 2 cycles,
  - on wb* after 3 cycles.
- **Reset.** rst=1 clears all pipeline registers to bubble and stallCount to 0, asynchronously and mid-operation included.
  - Result: all ex*/mem*/wb* outputs and dests are 0, pcWrite=1, ifIdWrite=1, ifIdFlush=0.
  - branchTaken=1 during reset still drives ifIdFlush=1 combinationally.
  - Registers stay cleared until the first edge after rst falls.
- **branchTaken and loadUse in the same cycle:** flush wins, as defined above.

## Test plan
- **Reset mid-stream.** Stream 3 instructions, assert rst between edges.
  - Expect all outputs 0 immediately.
  - Expect pcWrite=1, stallCount=0.
- **Pass-through.** Present idWriteBackControl=2'b10, idMemAccessControl=3'b000, idCalculationControl=4'b1100, idRd=5, idRt=3.
  - Next cycle: exDest=5.
  - +1 cycle: memWriteBackControl=2'b10, memDest=5.
  - +2 cycles: wbWriteBackControl=2'b10, wbDest=5.
- **Load-use.** Load (mem=3'b010, rt=8) then an instruction with idRs=8.
  - Exactly one cycle with pcWrite=0, ifIdWrite=0 and ex* = bubble the following cycle.
  - stallCount=1.
  - The dependent instruction reaches EX one cycle late.
- **No false stall.** Load to rt=0 followed by idRs=0; separately, load rt=8 followed by idRs=9, idRt=10.
  - pcWrite stays 1 and stallCount stays 0 in both cases.
- **Flush beats stall.** Branch in EX with branchTaken=1 while loadUse conditions also hold.
  - ifIdFlush=1, pcWrite=1.
  - Next ex* = bubble, memMemAccessControl[2]=1.
  - stallCount unchanged.
- **Saturation.** Set STALL_COUNT_WIDTH=2 and force 5 load-use stalls.
  - stallCount reads 1, 2, 3, 3, 3.
